// File: rtl/peri_uart_rx.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO.
// Status is polled through ctrl_o; pops, flag clears and flush go through we_ctrl_i.
module peri_uart_rx #(
   parameter int CLKS_PER_BIT = 1042,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        uart_rx_i,
   input  logic [31:0] data_i,
   input  logic        we_ctrl_i,
   output logic [31:0] data_o,
   output logic [31:0] ctrl_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = AW + 1;

   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        state_q;
   logic [CW-1:0] baud_q;
   logic [2:0]    idx_q;
   logic [7:0]    shift_q;
   logic          rx_meta_q;
   logic          rx_s_q;
   logic          rx_prev_q;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [NW-1:0] count_q, count_d;
   logic          ovr_q, ovr_d;
   logic          ferr_q, ferr_d;

   logic fall_w, baud_zero_w, stop_w;
   logic push_w, ferr_set_w;
   logic flush_w, pop_w, empty_w, full_w;
   logic wr_w, ovr_set_w;
   logic unused_w;

   assign unused_w    = ^{data_i[31:5], data_i[1]};
   assign fall_w      = rx_prev_q & ~rx_s_q;
   assign baud_zero_w = (baud_q == '0);

   // Single FSM block; the frame is sampled mid-bit from rx_s_q.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx_i;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
         unique case (state_q)
            S_IDLE: begin
               if (fall_w) begin
                  baud_q  <= HALF;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_zero_w) begin
                  if (rx_s_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     baud_q  <= FULL;
                     idx_q   <= '0;
                     state_q <= S_DATA;
                  end
               end else begin
                  baud_q <= baud_q - CW'(1);
               end
            end
            S_DATA: begin
               if (baud_zero_w) begin
                  shift_q <= {rx_s_q, shift_q[7:1]};
                  baud_q  <= FULL;
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= S_STOP;
               end else begin
                  baud_q <= baud_q - CW'(1);
               end
            end
            S_STOP: begin
               if (baud_zero_w) state_q <= S_IDLE;
               else             baud_q  <= baud_q - CW'(1);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stop_w     = (state_q == S_STOP) & baud_zero_w;
   assign push_w     = stop_w & rx_s_q;
   assign ferr_set_w = stop_w & ~rx_s_q;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == NW'(FIFO_DEPTH));
   assign flush_w = we_ctrl_i & data_i[4];
   assign pop_w   = we_ctrl_i & data_i[0] & ~empty_w & ~flush_w;

   // A pop in the same cycle frees the slot a full FIFO needs.
   assign wr_w      = push_w & ~flush_w & (~full_w | pop_w);
   assign ovr_set_w = push_w & ~flush_w & full_w & ~pop_w;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_w) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_w)  wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_w) rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({wr_w, pop_w})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
         endcase
      end
      ovr_d  = ovr_set_w  | (ovr_q  & ~(we_ctrl_i & data_i[2]));
      ferr_d = ferr_set_w | (ferr_q & ~(we_ctrl_i & data_i[3]));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovr_q    <= ovr_d;
         ferr_q   <= ferr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_w) mem_q[wr_ptr_q] <= shift_q;
   end

   assign data_o = empty_w ? 32'd0 : {24'd0, mem_q[rd_ptr_q]};
   assign ctrl_o = {24'd0, 4'(count_q), ferr_q, ovr_q, full_w, ~empty_w};

endmodule

// File: tb/tb_peri_uart_rx.sv
// Directed bench for peri_uart_rx at 16 clocks per bit.
// Frames are driven on the falling clock edge and outputs checked there too.
module tb_peri_uart_rx;

   localparam int CPB = 16;

   logic        clk;
   logic        reset;
   logic        rx;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] data;
   logic [31:0] ctrl;

   int n_chk  = 0;
   int n_pass = 0;

   peri_uart_rx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (8)
   ) dut (
      .clk_i    (clk),
      .reset_i  (reset),
      .uart_rx_i(rx),
      .data_i   (wdata),
      .we_ctrl_i(we),
      .data_o   (data),
      .ctrl_o   (ctrl)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   task automatic bit_out(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      bit_out(stop);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] d);
      wdata = d;
      we    = 1'b1;
      @(negedge clk);
      we    = 1'b0;
      wdata = '0;
      @(negedge clk);
   endtask

   initial begin
      rx    = 1'b1;
      we    = 1'b0;
      wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ctrl", ctrl, 32'h0);
      chk("rst_data", data, 32'h0);

      // single frame
      idle(5);
      send(8'hA5, 1'b1);
      idle(4);
      chk("a5_data", data, 32'h000000A5);
      chk("a5_ctrl", ctrl, 32'h00000011);
      wr(32'h1);
      chk("a5_pop", ctrl, 32'h0);

      // three back-to-back frames
      send(8'h01, 1'b1);
      send(8'h02, 1'b1);
      send(8'h03, 1'b1);
      idle(4);
      chk("b3_ctrl", ctrl, 32'h00000031);
      chk("b3_d0", data, 32'h01);
      wr(32'h1);
      chk("b3_d1", data, 32'h02);
      wr(32'h1);
      chk("b3_d2", data, 32'h03);
      wr(32'h1);
      chk("b3_end", ctrl, 32'h0);
      wr(32'h1);
      chk("pop_empty", ctrl, 32'h0);

      // overrun on the ninth byte
      for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 1'b1);
      idle(4);
      chk("ovr_ctrl", ctrl, 32'h00000087);
      chk("ovr_head", data, 32'h10);
      wr(32'h4);
      chk("ovr_clr", ctrl, 32'h00000083);
      chk("ovr_head2", data, 32'h10);
      wr(32'h10);
      chk("flush", ctrl, 32'h0);
      chk("flush_d", data, 32'h0);

      // framing error then a good frame
      send(8'h55, 1'b0);
      idle(3 * CPB);
      send(8'h33, 1'b1);
      idle(4);
      chk("ferr_ctrl", ctrl, 32'h00000019);
      chk("ferr_data", data, 32'h33);
      wr(32'h9);
      chk("ferr_clr", ctrl, 32'h0);

      // short glitch is rejected
      rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(3 * CPB);
      chk("glitch_ctrl", ctrl, 32'h0);
      chk("glitch_data", data, 32'h0);
      send(8'h5A, 1'b1);
      idle(4);
      chk("post_glitch_d", data, 32'h5A);
      chk("post_glitch_c", ctrl, 32'h00000011);

      // reset mid-frame with a byte still queued
      bit_out(1'b0);
      bit_out(1'b0);
      bit_out(1'b1);
      bit_out(1'b1);
      rx    = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ctrl", ctrl, 32'h0);
      chk("mid_rst_data", data, 32'h0);
      reset = 1'b0;
      idle(12 * CPB);
      chk("mid_rst_idle", ctrl, 32'h0);
      send(8'h42, 1'b1);
      idle(4);
      chk("r42_data", data, 32'h42);
      chk("r42_ctrl", ctrl, 32'h00000011);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
